seven_seg_display_ctrl: RTL and testbench
=========================================

# seven_seg_display_ctrl

Scan controller for the 4-digit multiplexed seven-segment display. It takes a 16-bit hex value through a valid/ready load port and applies it only at frame boundaries, so the display never shows a mix of old and new digits. It sequences one active-low anode per slot, with a programmable dead time between digits to suppress ghosting, and decodes each nibble to active-low segments with optional leading-zero blanking. It sits between the top-level datapath and the board's anode/cathode pins.

## Interface
- PRESCALE, 50000: clock cycles a digit is driven per slot; must be ≥ 1.
- BLANK_CYCLES, 1000: dead-time cycles after each digit (all anodes off); must be ≥ 1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  1 = scan, 0 = display dark and idle.
- lz_blank  in  1  1 = suppress leading zero digits.
- value_in  in  16  hex value; digit k = value_in[4k+3:4k]; digit 0 is rightmost.
- dp_in  in  4  decimal point per digit, 1 = lit.
- load  in  1  value_in/dp_in valid.
- ready  out  1  pending buffer free; a transfer occurs when load & ready.
- anode  out  4  active-low digit select; bit k = digit k.
- segment  out  7  active-low {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- States: IDLE, DRIVE, BLANK. A 2-bit digit index wraps 3→0. A prescale counter is shared by DRIVE and BLANK.
- IDLE:
  - anode=4'b1111, segment=7'h7F, dp=1.
  - Counter and index are held at 0.
  - Goes to DRIVE when enable=1.
- DRIVE:
  - anode has bit [index] low.
  - segment = decode(display nibble[index]); dp = ~display_dp[index].
  - Lasts PRESCALE cycles, then goes to BLANK.
- BLANK:
  - anode=1111, segment=7'h7F, dp=1.
  - Lasts BLANK_CYCLES cycles, then index increments and the state goes back to DRIVE.
- enable=0 in any state moves to IDLE on the next edge and clears the counter and index. The pending buffer is kept.
- Load path:
  - On load & ready, capture value_in/dp_in into the pending buffer and set the pending flag. ready = ~pending.
  - While ready=0, load is ignored.
- Commit:
  - Happens on the last BLANK cycle of index 3 (frame boundary).
  - If pending: display ← pending and the pending flag is cleared, so ready=1 on the next cycle.
  - frame_done pulses on this cycle whether or not anything was pending.
  - While IDLE, a pending value commits immediately, on the next edge, with no frame_done pulse.
- Leading-zero blanking:
  - Applies when lz_blank=1, to digit k>0 whose display nibbles k..3 are all zero.
  - A blanked digit in its DRIVE slot gives anode=1111, segment=7'h7F, and dp still from display_dp. If that dp is lit, the anode stays asserted.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Decode table, segment values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

## Timing
- Reset values:
  - state IDLE, index 0, counter 0.
  - display value 0, display_dp 0, pending flag clear.
  - anode=1111, segment=7F, dp=1, ready=1, frame_done=0.
- All outputs are registered and update on the same edge as the state register. No combinational path runs from inputs to outputs.
- enable rising:
  - Cycle after: DRIVE with index 0, anode=1110.
  - Slot length = PRESCALE+BLANK_CYCLES.
  - Frame length = 4×(PRESCALE+BLANK_CYCLES).
- Load-to-display latency:
  - Up to one frame plus one cycle.
  - ready returns high the cycle after frame_done.
- Reset is asserted asynchronously mid-frame. All outputs go to their reset values immediately, and a pending load is lost.
- Simultaneous load & ready on the commit cycle is impossible, because ready=0 whenever pending is set. If pending is clear at commit, the new load is captured into pending and displays at the next boundary.

## Structure
- Package seven_seg_pkg holds:
  - the state enum {IDLE, DRIVE, BLANK};
  - SEG_BLANK=7'h7F and ANODE_OFF=4'hF;
  - the 16-entry segment decode constants.
- Sub-module hex_to_7seg: purely combinational, 4-bit nibble in, 7-bit active-low segments out. It is reusable by other display blocks.

## Test plan
- Reset and idle:
  - Stimulus: PRESCALE=4, BLANK_CYCLES=2, enable=0, reset released.
  - Required: anode=1111, segment=7F, ready=1 for 50 cycles.
- Scan order:
  - Stimulus: enable=1, load 16'h1234.
  - Required: after commit, anode sequence is 1110(4 cycles, seg 19), 1111(2), 1101(seg 30), 1111, 1011(seg 24), 1111, 0111(seg 79), 1111; frame_done every 24 cycles.
- Tear-free update:
  - Stimulus: load 16'hABCD mid-frame.
  - Required: ready=0 until the cycle after the next frame_done; the remaining digits of the current frame still show the old value.
- Leading-zero blanking:
  - Stimulus: lz_blank=1, value 16'h0050, then 16'h0000.
  - For 16'h0050: digits 3 and 2 are dark (anode 1111), digit 1 shows 12, digit 0 shows 40.
  - For 16'h0000: only digit 0 shows 40.
- Disable and reset mid-operation:
  - Stimulus: drop enable during digit 2 DRIVE.
  - Required: anode=1111 on the next cycle; re-enabling restarts at digit 0.
  - Stimulus: assert reset asynchronously with a load pending.
  - Required: outputs go to reset values without waiting for a clock edge; after release the display shows 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StBlank
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; element n is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// Load port of the display controller: a 16-bit hex value plus decimal points, valid/ready.
interface seven_seg_display_ctrl_if;

    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        ready;

    modport master (
        output value,
        output dp,
        output load,
        input  ready
    );

    modport slave (
        input  value,
        input  dp,
        input  load,
        output ready
    );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// 4-digit multiplexed seven-segment scan controller with frame-aligned value updates,
// inter-digit dead time and optional leading-zero blanking.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned Prescale    = 50000,
    parameter int unsigned BlankCycles = 1000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     lz_blank_i,
    seven_seg_display_ctrl_if.slave  load_if,
    output logic [3:0]               anode_o,
    output logic [6:0]               segment_o,
    output logic                     dp_o,
    output logic                     frame_done_o
);

    localparam int unsigned CntMax = (Prescale > BlankCycles) ? Prescale : BlankCycles;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] DriveLast = CntW'(Prescale - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BlankCycles - 1);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [15:0] disp_val_q, disp_val_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pending_q, pending_d;

    logic [3:0]  anode_q, anode_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        frame_done_q, frame_done_d;

    logic        commit;
    logic [3:0]  nibble;
    logic [6:0]  seg_dec;
    logic        lz_digit;

    // Scan sequencing; enable low overrides everything and parks at digit 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StDrive;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                StDrive: begin
                    if (cnt_q == DriveLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // frame_done_q is high exactly during the last blank cycle of digit 3.
    assign commit = frame_done_q | (state_q == StIdle);

    // Pending buffer: commit needs pending set, capture needs it clear, so they never collide.
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pending_d  = pending_q;
        if (commit && pending_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            pending_d  = 1'b0;
        end
        if (load_if.load && !pending_q) begin
            pend_val_d = load_if.value;
            pend_dp_d  = load_if.dp;
            pending_d  = 1'b1;
        end
    end

    assign load_if.ready = ~pending_q;

    assign nibble = disp_val_d[{idx_d, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (nibble),
        .seg_o    (seg_dec)
    );

    always_comb begin
        case (idx_d)
            2'd1:    lz_digit = (disp_val_d[15:4] == 12'h000);
            2'd2:    lz_digit = (disp_val_d[15:8] == 8'h00);
            2'd3:    lz_digit = (disp_val_d[15:12] == 4'h0);
            default: lz_digit = 1'b0;
        endcase
    end

    // Outputs are computed from next-state values so they register on the same edge.
    always_comb begin
        anode_d      = ANODE_OFF;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frame_done_d = (state_d == StBlank) && (idx_d == 2'd3) && (cnt_d == BlankLast);
        if (state_d == StDrive) begin
            dp_d = ~disp_dp_d[idx_d];
            if (!(lz_blank_i && lz_digit)) begin
                anode_d[idx_d] = 1'b0;
                seg_d          = seg_dec;
            end else if (disp_dp_d[idx_d]) begin
                anode_d[idx_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            anode_q      <= ANODE_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode_o      = anode_q;
    assign segment_o    = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Randomized self-checking bench for seven_seg_display_ctrl against a time-position model.
module tb_seven_seg_display_ctrl;

    localparam int unsigned Prescale    = 4;
    localparam int unsigned BlankCycles = 2;
    localparam int Slot  = Prescale + BlankCycles;
    localparam int Frame = 4 * Slot;

    localparam logic [6:0] SegTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       lz_blank;
    logic [3:0] anode;
    logic [6:0] segment;
    logic       dp;
    logic       frame_done;

    seven_seg_display_ctrl_if ld_if ();

    seven_seg_display_ctrl #(
        .Prescale    (Prescale),
        .BlankCycles (BlankCycles)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .lz_blank_i   (lz_blank),
        .load_if      (ld_if),
        .anode_o      (anode),
        .segment_o    (segment),
        .dp_o         (dp),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_t counts cycles since scanning started (-1 when dark).
    int          m_t;
    logic [15:0] m_disp, m_pval;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_pend;
    logic [13:0] exp_vec;
    logic [13:0] act_vec;

    assign act_vec = {anode, segment, dp, frame_done, ld_if.ready};

    task automatic compute_exp();
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        logic       fd;
        int         pos;
        int         slot;
        logic       blanked;
        a  = 4'hF;
        s  = 7'h7F;
        d  = 1'b1;
        fd = 1'b0;
        if (m_t >= 0) begin
            pos     = m_t % Frame;
            slot    = pos / Slot;
            fd      = (pos == Frame - 1);
            blanked = lz_blank && (slot > 0) && ((m_disp >> (4 * slot)) == 16'h0);
            if ((pos % Slot) < Prescale) begin
                d = ~m_ddp[slot];
                if (!blanked) begin
                    a[slot] = 1'b0;
                    s       = SegTab[m_disp[4*slot +: 4]];
                end else if (m_ddp[slot]) begin
                    a[slot] = 1'b0;
                end
            end
        end
        exp_vec = {a, s, d, fd, ~m_pend};
    endtask

    task automatic model_reset();
        m_t    = -1;
        m_disp = '0;
        m_ddp  = '0;
        m_pval = '0;
        m_pdp  = '0;
        m_pend = 1'b0;
        compute_exp();
    endtask

    task automatic model_step();
        logic was_running;
        logic commit;
        logic pend0;
        was_running = (m_t >= 0);
        commit      = !was_running || ((m_t % Frame) == Frame - 1);
        pend0       = m_pend;
        if (commit && pend0) begin
            m_disp = m_pval;
            m_ddp  = m_pdp;
            m_pend = 1'b0;
        end
        if (ld_if.load && !pend0) begin
            m_pval = ld_if.value;
            m_pdp  = ld_if.dp;
            m_pend = 1'b1;
        end
        m_t = enable ? (was_running ? m_t + 1 : 0) : -1;
        compute_exp();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        ld_if.value = v;
        ld_if.dp    = d;
        ld_if.load  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        lz_blank    = 1'b0;
        ld_if.load  = 1'b0;
        ld_if.value = '0;
        ld_if.dp    = '0;
        #12;
        model_reset();
        n_tests++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_values act=%h exp=%h", act_vec, exp_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_tests++;
            if (act_vec !== exp_vec || anode !== 4'hF || segment !== 7'h7F) begin
                n_fail++;
                $display("FAIL idle_dark cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_scan_order();
        int last_fd;
        int cyc;
        enable = 1'b1;
        pulse_load(16'h1234, 4'b0000);
        tick();
        ld_if.load = 1'b0;
        n_tests++;
        if (anode !== 4'b1110 || act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL enable_start act=%h exp=%h anode=%b", act_vec, exp_vec, anode);
        end
        last_fd = -1;
        for (cyc = 0; cyc < 3 * Frame; cyc++) begin
            tick();
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL scan_order cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    n_tests++;
                    if (cyc - last_fd != Frame) begin
                        n_fail++;
                        $display("FAIL frame_period act=%0d exp=%0d", cyc - last_fd, Frame);
                    end
                end
                last_fd = cyc;
            end
        end
    endtask

    task automatic test_tear_free();
        int k;
        logic seen_fd;
        k = 0;
        while ((m_t < 0 || (m_t % Frame) != 8) && k < 100) begin
            tick();
            k++;
        end
        n_tests++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL tear_wait act=timeout exp=mid_frame");
        end
        pulse_load(16'hABCD, 4'b0101);
        tick();
        ld_if.load = 1'b0;
        seen_fd = 1'b0;
        k = 0;
        while (!seen_fd && k < 2 * Frame) begin
            n_tests++;
            if (act_vec !== exp_vec || ld_if.ready !== 1'b0) begin
                n_fail++;
                $display("FAIL tear_hold k=%0d act=%h exp=%h", k, act_vec, exp_vec);
            end
            seen_fd = (frame_done === 1'b1);
            tick();
            k++;
        end
        n_tests++;
        if (!seen_fd || ld_if.ready !== 1'b1 || act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL tear_release ready=%b act=%h exp=%h", ld_if.ready, act_vec, exp_vec);
        end
        for (int i = 0; i < Frame; i++) begin
            tick();
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL tear_new cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0007};
        logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b1000};
        lz_blank = 1'b1;
        for (int v = 0; v < 3; v++) begin
            pulse_load(vals[v], dps[v]);
            tick();
            ld_if.load = 1'b0;
            for (int i = 0; i < 2 * Frame; i++) begin
                tick();
                n_tests++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL lz_blank val=%h cyc=%0d act=%h exp=%h",
                             vals[v], i, act_vec, exp_vec);
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_disable();
        int k;
        k = 0;
        while ((m_t < 0 || (m_t % Frame) != 2 * Slot + 1) && k < 100) begin
            tick();
            k++;
        end
        n_tests++;
        if (k >= 100 || anode !== 4'b1011) begin
            n_fail++;
            $display("FAIL disable_wait k=%0d anode=%b exp=1011", k, anode);
        end
        enable = 1'b0;
        tick();
        n_tests++;
        if (anode !== 4'hF || act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL disable_dark act=%h exp=%h", act_vec, exp_vec);
        end
        for (int i = 0; i < 5; i++) tick();
        enable = 1'b1;
        tick();
        n_tests++;
        if (anode !== 4'b1110 || act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reenable_digit0 act=%h exp=%h", act_vec, exp_vec);
        end
        for (int i = 0; i < Frame; i++) begin
            tick();
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reenable_scan cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            ld_if.load  = ($urandom_range(0, 3) == 0);
            ld_if.value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ld_if.value[15:8] = 8'h00;
            ld_if.dp    = 4'($urandom);
            if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            tick();
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
        ld_if.load = 1'b0;
        lz_blank   = 1'b0;
        enable     = 1'b1;
    endtask

    task automatic test_async_reset();
        int k;
        tick();
        k = 0;
        while ((ld_if.ready !== 1'b1 || m_t < 0 || (m_t % Frame) < 3) && k < 200) begin
            tick();
            k++;
        end
        pulse_load(16'h9876, 4'b1111);
        tick();
        ld_if.load = 1'b0;
        n_tests++;
        if (k >= 200 || ld_if.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_before_reset k=%0d ready=%b exp=0", k, ld_if.ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL async_reset act=%h exp=%h", act_vec, exp_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < Frame + 2; i++) begin
            tick();
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_lz_blank();
        test_disable();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
